// File: rtl/prog_mem_ctrl.sv
// rtl/prog_mem_ctrl.sv - program memory with registered fetch, load port, power-up clear; optional parity via PMEM_PARITY_EN
module prog_mem_ctrl #(
  parameter int              ADDR_W  = 5,
  parameter int              DATA_W  = 32,
  parameter int              OP_W    = 5,
  parameter logic [OP_W-1:0] HALT_OP = 5'b11111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] inst_out,
  output logic              inst_valid,
  output logic              halt_seen,
  output logic              init_busy
`ifdef PMEM_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef PMEM_PARITY_EN
  // Extra top bit holds even parity of the data bits
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   inst_out_q, inst_out_d;
  logic                inst_valid_q, inst_valid_d;
  logic                halt_seen_q, halt_seen_d;
  logic [MEM_W-1:0]    mem_q [DEPTH];

  logic [MEM_W-1:0]    rd_word;
  logic                accept;
  logic                is_halt;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [MEM_W-1:0]    wr_data;

  // State, clear counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      inst_out_q   <= '0;
      inst_valid_q <= 1'b0;
      halt_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      inst_out_q   <= inst_out_d;
      inst_valid_q <= inst_valid_d;
      halt_seen_q  <= halt_seen_d;
    end
  end

  // Next state: sweep every word once, then run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = S_RUN;
    end
  end

  // FSM outputs
  always_comb begin
    init_busy   = (state_q == S_INIT);
    fetch_ready = (state_q == S_RUN) && !halt_seen_q;
  end

  // Fetch, halt tracking and write-port selection; reads see the pre-edge contents
  always_comb begin
    rd_word      = mem_q[fetch_addr];
    accept       = fetch_req && fetch_ready;
    is_halt      = (rd_word[DATA_W-1 -: OP_W] == HALT_OP);
    inst_out_d   = accept ? rd_word[DATA_W-1:0] : inst_out_q;
    inst_valid_d = accept;
    halt_seen_d  = halt_seen_q;
    if ((state_q == S_RUN) && ld_en) halt_seen_d = 1'b0;
    // A halt delivered on the same edge as a load keeps the flag set
    if (accept && is_halt) halt_seen_d = 1'b1;
    if (state_q == S_INIT) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_data = '0;
    end else begin
      wr_en   = ld_en;
      wr_addr = ld_addr;
`ifdef PMEM_PARITY_EN
      wr_data = {^ld_data, ld_data};
`else
      wr_data = ld_data;
`endif
    end
  end

  // Storage array; contents are defined by the clear sweep, not by reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

`ifdef PMEM_PARITY_EN
  logic par_err_q, par_err_d;

  // Parity check result travels with the fetched word
  always_comb begin
    par_err_d = accept && ((^rd_word[DATA_W-1:0]) != rd_word[DATA_W]);
  end

  // Parity error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`endif

  assign inst_out   = inst_out_q;
  assign inst_valid = inst_valid_q;
  assign halt_seen  = halt_seen_q;

endmodule
